dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate data cache controller between the pipeline's MEM stage and a slow line-wide data memory. It replaces the single-cycle data-memory port: hits complete in the MEM cycle, and misses raise a stall that freezes the pipeline until the refill (and any dirty writeback) finishes. The block contains the tag/valid/dirty state and line storage, and talks to memory through a req/ack line-transfer handshake.

## Interface
- NUM_SETS, 16, number of lines; power of two; index width IDX_W = log2(NUM_SETS)
- LINE_BITS, 256, line size in bits (32 bytes, 8 words); offset width 5
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- cpu_req_i  in  1  MEM-stage access valid (MemRead | MemWrite)
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address, word aligned
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data, valid when cpu_req_i & ~cpu_stall_o
- cpu_stall_o  out  1  freeze PC, all pipeline registers and MEM inputs
- mem_req_o  out  1  line transfer request
- mem_we_o  out  1  1 = writeback, 0 = refill read
- mem_addr_o  out  32  line address, bits [4:0] = 0
- mem_data_o  out  LINE_BITS  writeback line
- mem_data_i  in  LINE_BITS  refill line, valid in the mem_ack_i cycle
- mem_ack_i  in  1  one-cycle transfer-complete pulse

## Operation
- Address split: tag = addr[31:5+IDX_W], index = addr[4+IDX_W:5], word = addr[4:2].
- hit = valid[index] & (tag_array[index] == tag). Evaluated combinationally in IDLE only.
- States are IDLE, WRITEBACK, REFILL_REQ and REFILL_WR.
- IDLE:
  - No request: cpu_stall_o = 0.
  - Load hit: cpu_data_o = selected word, same cycle, no stall.
  - Store hit: the word is written at the clock edge, dirty is set to 1, no stall.
  - Miss: cpu_stall_o = 1. Go to WRITEBACK if the victim is valid & dirty; otherwise go to REFILL_REQ.
- WRITEBACK:
  - mem_req_o = 1, mem_we_o = 1.
  - mem_addr_o = {victim tag, index, 5'b0}; mem_data_o = victim line.
  - On mem_ack_i, go to REFILL_REQ.
- REFILL_REQ:
  - mem_req_o = 1, mem_we_o = 0, mem_addr_o = {tag, index, 5'b0}.
  - On mem_ack_i, capture mem_data_i and go to REFILL_WR.
- REFILL_WR:
  - Write the line; set tag; set valid = 1, dirty = 0.
  - Go to IDLE. The same access then re-evaluates as a hit, and a store then sets dirty.
- cpu_stall_o = 1 in every state other than IDLE.
- mem_req_o, mem_we_o, mem_addr_o and mem_data_o are decoded from the registered state and latched miss address only, so they are stable for the whole request.
- Boundary conditions:
  - mem_ack_i outside WRITEBACK/REFILL_REQ is ignored.
  - cpu_req_i dropping during a miss does not abort the miss; the line fill completes.
  - A tag match on an invalid line is a miss.
  - Index 0 and index NUM_SETS-1 behave identically to all other indices (no wrap effects).

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE; all valid and dirty bits = 0.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - cpu_data_o = 0, cpu_stall_o = 0.
  - Data and tag arrays need not be cleared.
- Reset mid-miss abandons the transfer. Memory must tolerate mem_req_o dropping without an ack.
- Hit latency: 0 cycles of stall.
- Clean miss, memory ack L ≥ 1 cycles after the request rises:
  - Cycle 0: miss detected, stall.
  - Cycles 1..L: REFILL_REQ.
  - Cycle L+1: REFILL_WR.
  - Cycle L+2: IDLE hit, stall low.
  - Total stall = L+2 cycles.
- Dirty miss: stall = L_wb + L_rd + 2 cycles.
- The captured miss address is latched on the IDLE miss cycle. The frozen pipeline keeps cpu_addr_i equal to that address.

## Structure
- Shared package dcache_pkg holds:
  - the state enum (IDLE, WRITEBACK, REFILL_REQ, REFILL_WR);
  - localparams IDX_W, TAG_W = 27-IDX_W, OFF_W = 5, WORDS = LINE_BITS/32.
- Sub-module dcache_sram holds the tag, valid, dirty and line arrays, with a single read/write port. Valid and dirty are cleared by rst_i.
- The controller contains the FSM, the hit compare, word select/merge and the memory-side muxing.

## Test plan
- Reset then load 0x0000_0040 (memory line holds word1 = 0x1111_2222):
  - Stall for L+2 cycles; mem_addr_o = 0x40, mem_we_o = 0.
  - Then cpu_data_o = 0x1111_2222; the next load to 0x44 hits with no stall.
- Store 0xDEAD_BEEF to 0x40 (hit): no stall; dirty[2] = 1; load 0x40 returns 0xDEAD_BEEF.
- Load 0x0000_0240 (same index 2, new tag):
  - WRITEBACK with mem_addr_o = 0x40 and mem_data_o word0 = 0xDEAD_BEEF, then refill from 0x240.
  - Stall = L_wb + L_rd + 2.
- Store miss to 0x0000_0460 (clean victim):
  - Refill only, no writeback.
  - Afterwards the line is dirty, and only word0 is changed from the refilled data.
- Assert rst_i during REFILL_REQ:
  - mem_req_o and cpu_stall_o drop immediately.
  - The same load afterwards misses again.
- Pulse mem_ack_i while in IDLE with no request: no state change, no array update.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;
    localparam int NUM_SETS  = 16;
    localparam int LINE_BITS = 256;
    localparam int IDX_W     = $clog2(NUM_SETS);
    localparam int OFF_W     = 5;
    localparam int TAG_W     = 27 - IDX_W;
    localparam int WORDS     = LINE_BITS / 32;
    localparam int WSEL_W    = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL_REQ,
        REFILL_WR
    } state_t;

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction
endpackage

// File: rtl/dcache_sram.sv
// Tag, valid, dirty and line storage with one combinational-read / clocked-write port.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     idx,
    output logic [TAG_W-1:0]     rd_tag,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 wr_en,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic                 wr_dirty,
    input  logic [LINE_BITS-1:0] wr_line
);
    logic [TAG_W-1:0]     tag_mem  [NUM_SETS];
    logic [LINE_BITS-1:0] line_mem [NUM_SETS];
    logic                 valid_reg [NUM_SETS];
    logic                 dirty_reg [NUM_SETS];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            tag_mem[idx]  <= wr_tag;
            line_mem[idx] <= wr_line;
        end
    end

    // Every write installs or updates a live line, so valid is always set.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SETS; gi++) begin : g_flags
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    valid_reg[gi] <= 1'b0;
                    dirty_reg[gi] <= 1'b0;
                end else if (wr_en && idx == IDX_W'(gi)) begin
                    valid_reg[gi] <= 1'b1;
                    dirty_reg[gi] <= wr_dirty;
                end
            end
        end
    endgenerate

    assign rd_tag   = tag_mem[idx];
    assign rd_line  = line_mem[idx];
    assign rd_valid = valid_reg[idx];
    assign rd_dirty = dirty_reg[idx];
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache: hit compare, miss FSM, memory handshake.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);
    state_t               state_reg, state_next;
    logic [TAG_W-1:0]     miss_tag_reg;
    logic [IDX_W-1:0]     miss_idx_reg;
    logic [LINE_BITS-1:0] refill_line_reg;

    logic [TAG_W-1:0]     cpu_tag;
    logic [IDX_W-1:0]     cpu_idx;
    logic [WSEL_W-1:0]    word_sel;
    logic [IDX_W-1:0]     sram_idx;
    logic [TAG_W-1:0]     rd_tag;
    logic                 rd_valid, rd_dirty;
    logic [LINE_BITS-1:0] rd_line, merged_line;
    logic                 hit, miss;
    logic                 wr_en, wr_dirty;
    logic [TAG_W-1:0]     wr_tag;
    logic [LINE_BITS-1:0] wr_line;
    logic                 unused_addr_bits;

    assign cpu_tag          = cpu_addr_i[31:OFF_W+IDX_W];
    assign cpu_idx          = cpu_addr_i[OFF_W+IDX_W-1:OFF_W];
    assign word_sel         = cpu_addr_i[OFF_W-1:2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    // Outside IDLE the arrays are addressed by the latched miss, not the live bus.
    assign sram_idx = (state_reg == IDLE) ? cpu_idx : miss_idx_reg;
    assign hit      = (state_reg == IDLE) && rd_valid && (rd_tag == cpu_tag);
    assign miss     = (state_reg == IDLE) && cpu_req_i && !hit;

    dcache_sram u_sram (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .idx      (sram_idx),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_tag   (wr_tag),
        .wr_dirty (wr_dirty),
        .wr_line  (wr_line)
    );

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_merge
            assign merged_line[gi*32 +: 32] =
                (word_sel == WSEL_W'(gi)) ? cpu_data_i : rd_line[gi*32 +: 32];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            miss_tag_reg <= '0;
            miss_idx_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (miss) begin
                miss_tag_reg <= cpu_tag;
                miss_idx_reg <= cpu_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_reg == REFILL_REQ && mem_ack_i) begin
            refill_line_reg <= mem_data_i;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (miss) state_next = (rd_valid && rd_dirty) ? WRITEBACK : REFILL_REQ;
            WRITEBACK:  if (mem_ack_i) state_next = REFILL_REQ;
            REFILL_REQ: if (mem_ack_i) state_next = REFILL_WR;
            REFILL_WR:  state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        cpu_data_o  = '0;
        cpu_stall_o = !rst_i && ((state_reg != IDLE) || miss);
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        wr_en       = 1'b0;
        wr_tag      = cpu_tag;
        wr_dirty    = 1'b1;
        wr_line     = merged_line;
        case (state_reg)
            IDLE: begin
                if (cpu_req_i && hit) begin
                    if (cpu_we_i) wr_en = 1'b1;
                    else          cpu_data_o = rd_line[{word_sel, 5'b0} +: 32];
                end
            end
            WRITEBACK: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = line_addr(rd_tag, miss_idx_reg);
                mem_data_o = rd_line;
            end
            REFILL_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = line_addr(miss_tag_reg, miss_idx_reg);
            end
            REFILL_WR: begin
                wr_en    = 1'b1;
                wr_tag   = miss_tag_reg;
                wr_dirty = 1'b0;
                wr_line  = refill_line_reg;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a behavioural line-wide memory responder.
module tb_dcache_controller;
    localparam int LAT_WB = 2;
    localparam int LAT_RD = 3;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_we_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [255:0] mem_lines [int unsigned];
    logic [31:0]  q_addr [$];
    logic         q_we [$];
    logic [255:0] q_data [$];
    logic         hold_ack = 1'b0;
    logic         spur_ack = 1'b0;
    int           unstable = 0;

    // Default memory word = 0xC000_0000 | its byte address; line 0x40 words 0/1 preset.
    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (mem_lines.exists(a)) return mem_lines[a];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'hC000_0000 | (a + 32'(4*w));
        if (a == 32'h40) begin
            l[31:0]  = 32'h1111_2222;
            l[63:32] = 32'h1111_2222;
        end
        return l;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : responder
        int cnt;
        logic [31:0] first_addr;
        cnt = 0;
        first_addr = '0;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i = 1'b0;
            if (spur_ack) begin
                mem_ack_i = 1'b1;
                mem_data_i = '1;
            end else if (mem_req_o && !hold_ack) begin
                if (cnt == 0) first_addr = mem_addr_o;
                else if (mem_addr_o != first_addr) unstable++;
                cnt++;
                if (cnt == (mem_we_o ? LAT_WB : LAT_RD)) begin
                    mem_ack_i = 1'b1;
                    q_addr.push_back(mem_addr_o);
                    q_we.push_back(mem_we_o);
                    q_data.push_back(mem_data_o);
                    if (mem_we_o) mem_lines[mem_addr_o] = mem_data_o;
                    else mem_data_i = line_of(mem_addr_o);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int stalls, output logic [31:0] rdata);
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdata;
        #1;
        stalls = 0;
        while (cpu_stall_o && stalls < 200) begin
            @(negedge clk_i);
            #1;
            stalls++;
        end
        rdata = cpu_data_o;
        $display("access we=%0d addr=%h wdata=%h stall=%0d rdata=%h", we, addr, wdata, stalls, rdata);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_stall;
        logic        exp_wb;
        logic [31:0] wb_addr;
        logic [31:0] wb_w0;
        logic        exp_rd;
        logic [31:0] rd_addr;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int st, n0, nexp;
        logic [31:0] rd;
        logic [255:0] wbl;

        vecs[0]  = '{1'b0, 32'h040, 32'h0, 32'h1111_2222, 5, 1'b0, 32'h0,   32'h0,         1'b1, 32'h040};
        vecs[1]  = '{1'b0, 32'h044, 32'h0, 32'h1111_2222, 0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0};
        vecs[2]  = '{1'b1, 32'h040, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h040, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h240, 32'h0, 32'hC000_0240, 7, 1'b1, 32'h040, 32'hDEAD_BEEF, 1'b1, 32'h240};
        vecs[5]  = '{1'b1, 32'h460, 32'hCAFE_F00D, 32'h0, 5, 1'b0, 32'h0,   32'h0,         1'b1, 32'h460};
        vecs[6]  = '{1'b0, 32'h464, 32'h0, 32'hC000_0464, 0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h460, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h060, 32'h0, 32'hC000_0060, 7, 1'b1, 32'h460, 32'hCAFE_F00D, 1'b1, 32'h060};
        vecs[9]  = '{1'b0, 32'h000, 32'h0, 32'hC000_0000, 5, 1'b0, 32'h0,   32'h0,         1'b1, 32'h000};
        vecs[10] = '{1'b0, 32'h1FC, 32'h0, 32'hC000_01FC, 5, 1'b0, 32'h0,   32'h0,         1'b1, 32'h1E0};
        vecs[11] = '{1'b1, 32'h1E0, 32'h1234_5678, 32'h0, 0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h3E0, 32'h0, 32'hC000_03E0, 7, 1'b1, 32'h1E0, 32'h1234_5678, 1'b1, 32'h3E0};
        vecs[13] = '{1'b0, 32'h000, 32'h0, 32'hC000_0000, 0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0};
        vecs[14] = '{1'b0, 32'h240, 32'h0, 32'hC000_0240, 0, 1'b0, 32'h0,   32'h0,         1'b0, 32'h0};
        vecs[15] = '{1'b0, 32'h040, 32'h0, 32'hDEAD_BEEF, 5, 1'b0, 32'h0,   32'h0,         1'b1, 32'h040};

        // Reset with a request pending: outputs must all be quiet.
        rst_i = 1'b1; cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40; cpu_data_i = '0;
        #12;
        chk("rst_stall", 256'(cpu_stall_o), 256'(0));
        chk("rst_mem_req", 256'(mem_req_o), 256'(0));
        chk("rst_mem_we", 256'(mem_we_o), 256'(0));
        chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        chk("rst_mem_data", mem_data_o, 256'(0));
        chk("rst_cpu_data", 256'(cpu_data_o), 256'(0));
        @(negedge clk_i);
        cpu_req_i = 1'b0; rst_i = 1'b0;

        for (int i = 0; i < 16; i++) begin
            n0 = q_addr.size();
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, st, rd);
            chk($sformatf("v%0d_stall", i), 256'(st), 256'(vecs[i].exp_stall));
            if (!vecs[i].we) chk($sformatf("v%0d_data", i), 256'(rd), 256'(vecs[i].exp_data));
            nexp = int'(vecs[i].exp_wb) + int'(vecs[i].exp_rd);
            chk($sformatf("v%0d_ntxn", i), 256'(q_addr.size() - n0), 256'(nexp));
            if (q_addr.size() - n0 == nexp) begin
                if (vecs[i].exp_wb) begin
                    chk($sformatf("v%0d_wb_we", i), 256'(q_we[n0]), 256'(1));
                    chk($sformatf("v%0d_wb_addr", i), 256'(q_addr[n0]), 256'(vecs[i].wb_addr));
                    wbl = q_data[n0];
                    chk($sformatf("v%0d_wb_w0", i), 256'(wbl[31:0]), 256'(vecs[i].wb_w0));
                end
                if (vecs[i].exp_rd) begin
                    chk($sformatf("v%0d_rd_we", i), 256'(q_we[n0+nexp-1]), 256'(0));
                    chk($sformatf("v%0d_rd_addr", i), 256'(q_addr[n0+nexp-1]), 256'(vecs[i].rd_addr));
                end
            end
        end
        // Untouched words of written-back lines keep their refilled/preset values.
        wbl = mem_lines[32'h40];
        chk("wb40_w1", 256'(wbl[63:32]), 256'(32'h1111_2222));
        wbl = mem_lines[32'h460];
        chk("wb460_w1", 256'(wbl[63:32]), 256'(32'hC000_0464));

        // Reset while waiting in REFILL_REQ.
        hold_ack = 1'b1;
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h800;
        @(negedge clk_i);
        #1;
        chk("mid_req_before", 256'(mem_req_o), 256'(1));
        chk("mid_addr_before", 256'(mem_addr_o), 256'(32'h800));
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_req", 256'(mem_req_o), 256'(0));
        chk("mid_rst_stall", 256'(cpu_stall_o), 256'(0));
        @(negedge clk_i);
        rst_i = 1'b0; cpu_req_i = 1'b0; hold_ack = 1'b0;
        access(1'b0, 32'h800, 32'h0, st, rd);
        chk("after_rst_stall", 256'(st), 256'(5));
        chk("after_rst_data", 256'(rd), 256'(32'hC000_0800));
        access(1'b0, 32'h000, 32'h0, st, rd);
        chk("valid_cleared_stall", 256'(st), 256'(5));

        // Stray ack in IDLE with no request.
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        @(posedge clk_i); spur_ack = 1'b1;
        @(posedge clk_i); spur_ack = 1'b0;
        #1;
        chk("spur_stall", 256'(cpu_stall_o), 256'(0));
        chk("spur_req", 256'(mem_req_o), 256'(0));
        access(1'b0, 32'h000, 32'h0, st, rd);
        chk("spur_hit_stall", 256'(st), 256'(0));
        chk("spur_hit_data", 256'(rd), 256'(32'hC000_0000));

        // Request withdrawn mid-miss: the fill still completes.
        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0A0;
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        #1;
        st = 0;
        while (cpu_stall_o && st < 50) begin
            @(negedge clk_i);
            #1;
            st++;
        end
        chk("drop_fill_done", 256'(cpu_stall_o), 256'(0));
        access(1'b0, 32'h0A0, 32'h0, st, rd);
        chk("drop_hit_stall", 256'(st), 256'(0));
        chk("drop_hit_data", 256'(rd), 256'(32'hC000_00A0));

        chk("mem_addr_stable", 256'(unstable), 256'(0));
        cpu_req_i = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
